// File: rtl/mul_share_arbiter.sv
// Two-channel front end that time-shares one multi_4bits multiplier.
// Grants are round-robin, and only one operation is in flight at a time.
// Each result is returned with the ID of the channel that issued it, and the
// result port supports backpressure.

// Unsigned multiplier with a fixed pipeline latency of LAT cycles (LAT=0 is combinational).
module multi_4bits #(
    parameter int unsigned bits = 4,
    parameter int unsigned LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [bits-1:0]   A_i,
    input  logic [bits-1:0]   B_i,
    output logic [2*bits-1:0] Product_o
);

    logic [2*bits-1:0] prod;

    // Full-width product; operands are zero-extended so nothing is truncated.
    always_comb begin
        prod = {{bits{1'b0}}, A_i} * {{bits{1'b0}}, B_i};
    end

    generate
        if (LAT == 0) begin : g_comb
            // Zero-latency configuration: the product is visible immediately.
            always_comb begin
                Product_o = prod;
            end
        end else begin : g_pipe
            logic [LAT-1:0][2*bits-1:0] pipe_q;

            // Shift the product through LAT register stages.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q[0] <= prod;
                    for (int unsigned i = 1; i < LAT; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            // The last stage is the registered product.
            always_comb begin
                Product_o = pipe_q[LAT-1];
            end
        end
    endgenerate

endmodule

module mul_share_arbiter #(
    parameter int unsigned bits    = 4,
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [bits-1:0]   req0_a,
    input  logic [bits-1:0]   req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [bits-1:0]   req1_a,
    input  logic [bits-1:0]   req1_b,
    output logic              req1_ready,
    output logic              res_valid,
    output logic              res_id,
    output logic [2*bits-1:0] res_p,
    input  logic              res_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    localparam int unsigned LAT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [bits-1:0]   op_a_q, op_a_d;
    logic [bits-1:0]   op_b_q, op_b_d;
    logic              op_id_q, op_id_d;
    logic              rr_last_q, rr_last_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              res_valid_q, res_valid_d;
    logic              res_id_q, res_id_d;
    logic [2*bits-1:0] res_p_q, res_p_d;
    logic [CNT_W-1:0]  ops_q, ops_d;

    logic [2*bits-1:0] product;
    logic              grant_vld;
    logic              grant_id;

    // The operand registers stay constant throughout BUSY, so they feed the
    // multiplier directly.
    multi_4bits #(
        .bits (bits),
        .LAT  (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .A_i       (op_a_q),
        .B_i       (op_b_q),
        .Product_o (product)
    );

    // Round-robin pick: a lone requester wins; on contention the channel not served last wins.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~rr_last_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    // Next-state and handshake logic; readies are only raised in IDLE and never during reset.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rr_last_d   = rr_last_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_p_d     = res_p_q;
        ops_d       = ops_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_vld && !rst) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    op_a_d     = grant_id ? req1_a : req0_a;
                    op_b_d     = grant_id ? req1_b : req0_b;
                    op_id_d    = grant_id;
                    rr_last_d  = grant_id;
                    cnt_d      = LAT_W'(MUL_LAT);
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    res_p_d     = product;
                    res_id_d    = op_id_q;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    ops_d       = ops_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_p_q     <= '0;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rr_last_q   <= rr_last_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_p_q     <= res_p_d;
            ops_q       <= ops_d;
        end
    end

    // Registered outputs.
    always_comb begin
        res_valid = res_valid_q;
        res_id    = res_id_q;
        res_p     = res_p_q;
        ops_done  = ops_q;
        busy      = (state_q != IDLE);
    end

endmodule
